conv_host_sequencer: RTL and testbench
======================================

Name: conv_host_sequencer

Overview:
Host-side initiator for the conv address FSM's load/process/read protocol, i.e. the other end of the FSM's i_load/i_SoP/i_valid/o_EoP/o_changeBlock interface. Takes LOAD/RUN/READ commands and a ready/valid host word stream. Drives load, SoP, valid pulses and pixel data towards the FSM and image memories, then returns processed pixels to the host. Sits between the host GPIO bridge and the conv datapath.

Parameters:
NB_IMAGE, 10, width of image length / pixel counter
NB_DATA, 8, pixel data width
PULSE_HI, 2, cycles o_valid is held high per pulse (>=1)
PULSE_LO, 2, cycles o_valid is held low after each pulse (>=1; also read-data settle time)
NB_TIMEOUT, 16, width of RUN timeout counter; timeout = 2^NB_TIMEOUT-1 cycles

Ports:
i_CLK  in  1  clock
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_cmd  in  2  01=LOAD, 10=RUN, 11=READ, 00=none
i_cmdStart  in  1  one-cycle command strobe
i_imgLength  in  NB_IMAGE  last pixel index; latched at command accept
i_hostData  in  NB_DATA  host pixel in
i_hostValid  in  1  host pixel valid
o_hostReady  out  1  sequencer accepts host pixel
o_hostData  out  NB_DATA  pixel out to host
o_hostValid  out  1  output pixel valid
i_hostReady  in  1  host accepts output pixel
o_load  out  1  to FSM i_load
o_SoP  out  1  to FSM i_SoP
o_valid  out  1  to FSM i_valid (pulse train)
o_data  out  NB_DATA  pixel to image memory write port
i_data  in  NB_DATA  pixel from result memory read port
i_EoP  in  1  from FSM o_EoP
i_changeBlock  in  1  from FSM o_changeBlock
o_busy  out  1  command in progress
o_done  out  1  one-cycle completion pulse
o_error  out  1  one-cycle error pulse

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE, all outputs 0, counters 0. Mid-operation reset aborts immediately, with no pulse completed.
- IDLE: o_busy=0. i_cmdStart with i_cmd!=00 is accepted: latch len=i_imgLength, clear pixel count, o_busy=1 next cycle. i_cmdStart while busy is ignored. i_cmd=00 is ignored.
- LOAD: o_load=1 from the cycle after accept until completion; o_SoP=0.
  - Per pixel: o_hostReady=1 (only in LOAD_REQ); on i_hostValid&&o_hostReady, register o_data. o_valid goes high the next cycle for PULSE_HI cycles, then low for PULSE_LO cycles.
  - First o_valid rise is at least 2 cycles after o_load rises.
  - Issues exactly len+1 pulses. o_data stays stable from before each rise until after its fall.
  - Then LOAD_WAIT: wait i_changeBlock=1. Next cycle: o_load=0, o_done=1, go to IDLE.
- RUN: if i_EoP=1 at accept, pulse o_error and return to IDLE.
  - Otherwise o_SoP=1 with o_load=0, and the timeout counter runs.
  - When i_EoP=1: next cycle o_SoP=0, o_done=1, go to IDLE.
  - If the counter saturates before i_EoP: o_SoP=0, o_error=1, go to IDLE.
- READ: requires i_EoP=1 at accept, else o_error pulse and return to IDLE. o_load=0, o_SoP=0 throughout.
  - Per word: wait PULSE_LO cycles (settle), capture i_data into o_hostData, then hold o_hostValid=1 until i_hostReady. A backpressure stall holds o_hostData stable.
  - After the handshake, issue one o_valid pulse, which advances the FSM read address.
  - Words = len+1. After the last pulse, wait i_changeBlock=1, then o_done, go to IDLE.
- o_valid is never high in two consecutive pulses without >=PULSE_LO low cycles between them; the FSM edge-detects o_valid.
- len=0: exactly one pixel/word. Counter width is NB_IMAGE+1, so len=2^NB_IMAGE-1 does not wrap.
- o_done and o_error are mutually exclusive and one cycle wide.

Test Plan:
- Reset held low 3 cycles mid-LOAD -> all outputs 0 next cycle. LOAD then accepted immediately after release.
- LOAD, len=3, host data 0x11,0x22,0x33,0x44 with no stalls -> 4 o_valid pulses, 2 high/2 low each, o_data matching in order. i_changeBlock at cycle N gives o_load=0 and o_done at N+1.
- LOAD with i_hostValid dropped 5 cycles between pixels 1 and 2 -> o_valid stays low during the gap, pulse count still 4, no data loss.
- RUN, i_EoP raised 40 cycles later -> o_SoP high 40 cycles, then low with o_done one cycle later. RUN with i_EoP already 1 -> o_error only, o_SoP never asserted.
- READ, len=2, i_data 0xA0/0xA1/0xA2 per address, i_hostReady stalled 3 cycles on word 1 -> host receives A0,A1,A2, o_hostData stable while stalled, exactly 3 pulses, o_done after i_changeBlock.
- i_cmdStart during RUN -> ignored. READ with i_EoP=0 -> o_error, no o_valid pulses.

Source files
------------

// File: rtl/conv_host_sequencer.sv
// rtl/conv_host_sequencer.sv - host-side LOAD/RUN/READ initiator for the conv address FSM
module conv_host_sequencer #(
    parameter int NB_IMAGE   = 10,
    parameter int NB_DATA    = 8,
    parameter int PULSE_HI   = 2,
    parameter int PULSE_LO   = 2,
    parameter int NB_TIMEOUT = 16
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic [1:0]          i_cmd,
    input  logic                i_cmdStart,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_DATA-1:0]  i_hostData,
    input  logic                i_hostValid,
    output logic                o_hostReady,
    output logic [NB_DATA-1:0]  o_hostData,
    output logic                o_hostValid,
    input  logic                i_hostReady,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_data,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_EoP,
    input  logic                i_changeBlock,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_START, S_LOAD_REQ, S_LOAD_HI, S_LOAD_LO, S_LOAD_WAIT,
        S_RUN, S_READ_SETTLE, S_READ_HOLD, S_READ_HI, S_READ_WAIT
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;
    localparam logic [7:0] HI_LAST  = 8'(PULSE_HI - 1);
    localparam logic [7:0] LO_LAST  = 8'(PULSE_LO - 1);

    state_t              state_q, state_d;
    logic [NB_IMAGE-1:0] len_q, len_d;
    logic [NB_IMAGE:0]   cnt_q, cnt_d;
    logic [7:0]          tmr_q, tmr_d;
    logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
    logic [NB_DATA-1:0]  data_q, data_d;
    logic [NB_DATA-1:0]  hdata_q, hdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                last_pix;

    // cnt_q is one bit wider than len so a full-length image never wraps
    assign last_pix = (cnt_q == {1'b0, len_q});

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        hdata_d = hdata_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_cmdStart) begin
                    case (i_cmd)
                        CMD_LOAD: begin
                            len_d   = i_imgLength;
                            cnt_d   = '0;
                            tmr_d   = '0;
                            state_d = S_LOAD_START;
                        end
                        CMD_RUN: begin
                            if (i_EoP) begin
                                error_d = 1'b1;
                            end else begin
                                tmo_d   = '0;
                                state_d = S_RUN;
                            end
                        end
                        CMD_READ: begin
                            if (!i_EoP) begin
                                error_d = 1'b1;
                            end else begin
                                len_d   = i_imgLength;
                                cnt_d   = '0;
                                tmr_d   = '0;
                                state_d = S_READ_SETTLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // extra cycle keeps the first o_valid rise two cycles behind o_load
            S_LOAD_START: state_d = S_LOAD_REQ;
            S_LOAD_REQ: begin
                if (i_hostValid) begin
                    data_d  = i_hostData;
                    tmr_d   = '0;
                    state_d = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (tmr_q == HI_LAST) begin
                    tmr_d   = '0;
                    state_d = S_LOAD_LO;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_LOAD_LO: begin
                if (tmr_q == LO_LAST) begin
                    tmr_d = '0;
                    if (last_pix) begin
                        state_d = S_LOAD_WAIT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_LOAD_REQ;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_LOAD_WAIT: begin
                if (i_changeBlock) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_EoP) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (&tmo_q) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            // the low phase after each read pulse doubles as the memory settle time
            S_READ_SETTLE: begin
                if (tmr_q == LO_LAST) begin
                    tmr_d   = '0;
                    hdata_d = i_data;
                    state_d = S_READ_HOLD;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_READ_HOLD: begin
                if (i_hostReady) begin
                    state_d = S_READ_HI;
                end
            end
            S_READ_HI: begin
                if (tmr_q == HI_LAST) begin
                    tmr_d = '0;
                    if (last_pix) begin
                        state_d = S_READ_WAIT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_READ_SETTLE;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_READ_WAIT: begin
                if (i_changeBlock) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            hdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            hdata_q <= hdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_load      = (state_q == S_LOAD_START) || (state_q == S_LOAD_REQ) ||
                         (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO) ||
                         (state_q == S_LOAD_WAIT);
    assign o_SoP       = (state_q == S_RUN);
    assign o_valid     = (state_q == S_LOAD_HI) || (state_q == S_READ_HI);
    assign o_hostReady = (state_q == S_LOAD_REQ);
    assign o_hostValid = (state_q == S_READ_HOLD);
    assign o_data      = data_q;
    assign o_hostData  = hdata_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_conv_host_sequencer.sv
// tb/tb_conv_host_sequencer.sv - self-checking bench for conv_host_sequencer
module tb_conv_host_sequencer;
    localparam int NB_IMAGE = 10, NB_DATA = 8, PULSE_HI = 2, PULSE_LO = 2, NB_TIMEOUT = 16;

    logic i_CLK = 1'b0;
    logic i_reset = 1'b0;
    logic [1:0] i_cmd = '0;
    logic i_cmdStart = 1'b0;
    logic [NB_IMAGE-1:0] i_imgLength = '0;
    logic [NB_DATA-1:0] i_hostData = '0;
    logic i_hostValid = 1'b0;
    logic o_hostReady;
    logic [NB_DATA-1:0] o_hostData;
    logic o_hostValid;
    logic i_hostReady = 1'b0;
    logic o_load, o_SoP, o_valid;
    logic [NB_DATA-1:0] o_data;
    logic [NB_DATA-1:0] i_data;
    logic i_EoP = 1'b0;
    logic i_changeBlock = 1'b0;
    logic o_busy, o_done, o_error;

    always #5 i_CLK = ~i_CLK;

    conv_host_sequencer #(
        .NB_IMAGE(NB_IMAGE), .NB_DATA(NB_DATA), .PULSE_HI(PULSE_HI),
        .PULSE_LO(PULSE_LO), .NB_TIMEOUT(NB_TIMEOUT)
    ) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_cmd(i_cmd), .i_cmdStart(i_cmdStart),
        .i_imgLength(i_imgLength), .i_hostData(i_hostData), .i_hostValid(i_hostValid),
        .o_hostReady(o_hostReady), .o_hostData(o_hostData), .o_hostValid(o_hostValid),
        .i_hostReady(i_hostReady), .o_load(o_load), .o_SoP(o_SoP), .o_valid(o_valid),
        .o_data(o_data), .i_data(i_data), .i_EoP(i_EoP), .i_changeBlock(i_changeBlock),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {o_busy, o_load, o_SoP, o_valid, o_hostReady, o_done, o_error};
    endfunction

    // result memory: FSM read address advances on each o_valid rising edge
    logic [NB_IMAGE:0] rd_addr;
    logic rd_clr = 1'b0;
    logic prev_v_p = 1'b0;
    always @(posedge i_CLK) begin
        if (rd_clr) rd_addr <= '0;
        else if (o_valid && !prev_v_p) rd_addr <= rd_addr + 1'b1;
        prev_v_p <= o_valid;
    end
    assign i_data = 8'hA0 + rd_addr[7:0];

    // pulse-shape monitor
    int cyc = 0, load_rise_cyc = -1, first_valid_cyc = -1;
    int hi_run = 0, lo_run = 0;
    logic have_prev = 1'b0, prev_v = 1'b0, prev_l = 1'b0;
    logic [7:0] rise_data = '0;
    logic [7:0] mon_data[$];
    always @(negedge i_CLK) begin
        cyc++;
        if (o_done || o_error) chk("done_err_excl", {31'd0, o_done && o_error}, 0);
        if (o_load && !prev_l) begin
            load_rise_cyc   = cyc;
            first_valid_cyc = -1;
        end
        if (!i_reset) begin
            have_prev = 1'b0;
            hi_run = 0;
            lo_run = 0;
        end else if (o_valid) begin
            if (!prev_v) begin
                if (have_prev) chk("valid_lo_gap", {31'd0, lo_run >= PULSE_LO}, 1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                mon_data.push_back(o_data);
                rise_data = o_data;
                hi_run = 1;
            end else begin
                hi_run++;
            end
        end else begin
            if (prev_v) begin
                chk("valid_hi_width", hi_run, PULSE_HI);
                if (o_load) chk("data_hold", o_data, rise_data);
                have_prev = 1'b1;
                lo_run = 1;
            end else begin
                lo_run++;
            end
        end
        prev_v = o_valid;
        prev_l = o_load;
    end

    typedef struct {
        logic       start;
        logic [1:0] cmd;
        logic       eop;
        logic [6:0] exp1;
        logic [6:0] exp2;
    } vec_t;
    vec_t vecs[8];

    task automatic do_reset();
        i_reset = 1'b0; i_cmdStart = 1'b0; i_hostValid = 1'b0; i_hostReady = 1'b0;
        i_changeBlock = 1'b0; i_EoP = 1'b0;
        repeat (2) @(negedge i_CLK);
        i_reset = 1'b1;
    endtask

    task automatic load_body(input logic [7:0] px[4], input int gap_after, input int base);
        for (int i = 0; i < 4; i++) begin
            i_hostData = px[i];
            i_hostValid = 1'b1;
            for (int k = 0; k < 40 && !o_hostReady; k++) @(negedge i_CLK);
            chk("load_ready", {31'd0, o_hostReady}, 1);
            @(negedge i_CLK);
            i_hostValid = 1'b0;
            i_hostData = ~px[i];
            if (i == gap_after) begin
                for (int k = 0; k < 40 && !o_hostReady; k++) @(negedge i_CLK);
                for (int s = 0; s < 5; s++) begin
                    chk("gap_idle", {30'd0, o_valid, o_hostReady}, 1);
                    @(negedge i_CLK);
                end
            end
        end
        for (int k = 0; k < 60 && !((mon_data.size() - base) >= 4 && !o_valid); k++) @(negedge i_CLK);
        repeat (4) @(negedge i_CLK);
        chk("load_pulses", mon_data.size() - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("load_data%0d", i), mon_data[base + i], px[i]);
        chk("load_wait", {29'd0, o_load, o_done, o_busy}, 3'b101);
        i_changeBlock = 1'b1;
        @(negedge i_CLK);
        i_changeBlock = 1'b0;
        chk("load_done", {29'd0, o_load, o_done, o_busy}, 3'b010);
        @(negedge i_CLK);
        chk("load_done_width", {31'd0, o_done}, 0);
    endtask

    initial begin
        logic [6:0] o1, o2;
        logic [7:0] px_b[4];
        logic [7:0] px_c[4];
        logic [7:0] d;
        int base, sop_cnt;

        vecs[0] = '{1'b1, 2'b00, 1'b0, 7'b0000000, 7'b0000000};
        vecs[1] = '{1'b1, 2'b01, 1'b0, 7'b1100000, 7'b1100100};
        vecs[2] = '{1'b1, 2'b01, 1'b1, 7'b1100000, 7'b1100100};
        vecs[3] = '{1'b1, 2'b10, 1'b0, 7'b1010000, 7'b1010000};
        vecs[4] = '{1'b1, 2'b10, 1'b1, 7'b0000001, 7'b0000000};
        vecs[5] = '{1'b1, 2'b11, 1'b1, 7'b1000000, 7'b1000000};
        vecs[6] = '{1'b1, 2'b11, 1'b0, 7'b0000001, 7'b0000000};
        vecs[7] = '{1'b0, 2'b01, 1'b0, 7'b0000000, 7'b0000000};
        px_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        px_c = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};

        rd_clr = 1'b1;
        repeat (3) @(negedge i_CLK);
        rd_clr = 1'b0;
        chk("reset_outs", {9'd0, outs(), o_data, o_hostData}, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            i_cmd = vecs[i].cmd; i_imgLength = 10'd3; i_EoP = vecs[i].eop;
            i_cmdStart = vecs[i].start;
            @(negedge i_CLK);
            o1 = outs();
            i_cmdStart = 1'b0;
            @(negedge i_CLK);
            o2 = outs();
            chk($sformatf("vec%0d_c1", i), {25'd0, o1}, {25'd0, vecs[i].exp1});
            chk($sformatf("vec%0d_c2", i), {25'd0, o2}, {25'd0, vecs[i].exp2});
        end

        // reset mid-LOAD, then LOAD accepted on the release cycle
        do_reset();
        i_cmd = 2'b01; i_imgLength = 10'd3; i_cmdStart = 1'b1;
        @(negedge i_CLK);
        i_cmdStart = 1'b0; i_hostValid = 1'b1; i_hostData = 8'h99;
        for (int k = 0; k < 20 && !o_valid; k++) @(negedge i_CLK);
        chk("pre_rst_valid", {31'd0, o_valid}, 1);
        i_reset = 1'b0;
        @(negedge i_CLK);
        chk("rst_mid_outs", {17'd0, outs(), o_data}, 0);
        i_hostValid = 1'b0;
        repeat (2) @(negedge i_CLK);
        i_reset = 1'b1; i_cmd = 2'b01; i_imgLength = 10'd3; i_cmdStart = 1'b1;
        base = mon_data.size();
        @(negedge i_CLK);
        i_cmdStart = 1'b0;
        chk("accept_after_rst", {25'd0, outs()}, 7'b1100000);
        load_body(px_b, -1, base);
        chk("load_to_valid", first_valid_cyc - load_rise_cyc, 2);

        // LOAD with a host stall between pixels 1 and 2
        base = mon_data.size();
        i_cmd = 2'b01; i_imgLength = 10'd3; i_cmdStart = 1'b1;
        @(negedge i_CLK);
        i_cmdStart = 1'b0;
        load_body(px_c, 1, base);

        // RUN for 40 cycles, with a stray command strobe that must be ignored
        i_cmd = 2'b10; i_EoP = 1'b0; i_cmdStart = 1'b1;
        @(negedge i_CLK);
        i_cmdStart = 1'b0;
        chk("run_start", {29'd0, o_SoP, o_load, o_busy}, 3'b101);
        sop_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (o_SoP) sop_cnt++;
            if (k == 5) begin i_cmd = 2'b01; i_cmdStart = 1'b1; end
            if (k == 6) begin
                i_cmdStart = 1'b0;
                chk("run_ignore_cmd", {29'd0, o_SoP, o_load, o_hostReady}, 3'b100);
            end
            if (k == 40) i_EoP = 1'b1;
            else @(negedge i_CLK);
        end
        @(negedge i_CLK);
        chk("run_sop_cycles", sop_cnt, 40);
        chk("run_end", {28'd0, o_SoP, o_done, o_error, o_busy}, 4'b0100);
        @(negedge i_CLK);
        chk("run_done_width", {31'd0, o_done}, 0);

        // READ len=2 with a 3-cycle host stall on word 1
        rd_clr = 1'b1;
        @(negedge i_CLK);
        rd_clr = 1'b0;
        i_EoP = 1'b1; i_cmd = 2'b11; i_imgLength = 10'd2; i_cmdStart = 1'b1;
        base = mon_data.size();
        @(negedge i_CLK);
        i_cmdStart = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 40 && !o_hostValid; k++) @(negedge i_CLK);
            chk("read_hvalid", {31'd0, o_hostValid}, 1);
            d = o_hostData;
            chk($sformatf("read_word%0d", w), d, 8'hA0 + w);
            chk("read_ld_sop", {30'd0, o_load, o_SoP}, 0);
            if (w == 1) begin
                for (int s = 1; s < 3; s++) begin
                    @(negedge i_CLK);
                    chk("stall_valid", {31'd0, o_hostValid}, 1);
                    chk("stall_data", o_hostData, d);
                end
            end
            i_hostReady = 1'b1;
            @(negedge i_CLK);
            i_hostReady = 1'b0;
        end
        for (int k = 0; k < 60 && !((mon_data.size() - base) >= 3 && !o_valid); k++) @(negedge i_CLK);
        repeat (3) @(negedge i_CLK);
        chk("read_pulses", mon_data.size() - base, 3);
        chk("read_addr", rd_addr, 3);
        chk("read_wait", {28'd0, o_load, o_SoP, o_done, o_busy}, 4'b0001);
        i_changeBlock = 1'b1;
        @(negedge i_CLK);
        i_changeBlock = 1'b0;
        chk("read_done", {30'd0, o_done, o_busy}, 2'b10);

        // READ without EoP: error only, no pulses
        i_EoP = 1'b0;
        base = mon_data.size();
        i_cmd = 2'b11; i_cmdStart = 1'b1;
        @(negedge i_CLK);
        i_cmdStart = 1'b0;
        chk("read_noeop_err", {29'd0, o_error, o_done, o_busy}, 3'b100);
        repeat (6) @(negedge i_CLK);
        chk("read_noeop_pulses", mon_data.size() - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
